// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter and the decode control unit.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2,
    RESP     = 2'd3
  } arb_state_t;

  // MEM-stage control code: MSB enables an access, LSB selects write.
  localparam int         MEM_CTRL_EN_BIT = 1;
  localparam int         MEM_CTRL_WE_BIT = 0;
  localparam logic [1:0] MEM_LOAD        = 2'b10;
  localparam logic [1:0] MEM_STORE       = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_rr_grant2.sv
// Two-requester round-robin picker. When both requesters are pending, the one
// that did not win last time is picked. Holds last_grant (0 = IF, 1 = MEM).
module rr_grant2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_if,
  input  logic req_mem,
  input  logic take,
  output logic pick_mem,
  output logic last_mem
);

  // MEM wins when it is the only requester or IF had the last grant.
  always_comb begin
    pick_mem = req_mem & (~req_if | ~last_mem);
  end

  // Remember the winner once the grant is actually taken.
  always_ff @(posedge clk) begin
    if (!rst_n)    last_mem <= 1'b0;
    else if (take) last_mem <= pick_mem;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory bus between instruction fetch and the MEM stage.
// One transaction at a time, req/ack handshake, one RESP turnaround cycle.
// Optional: define MEM_TIMEOUT_EN to abort a transaction that sees no ack
// within TIMEOUT_CYCLES busy cycles (bus_err pulses with the ready).
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic [1:0]    mem_ctrl,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_ready,
  output logic          stall,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          bus_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t state, state_nxt;
  logic       mem_pend, pend, grant, pick_mem, last_mem, busy, done, tmo;

  assign mem_pend = mem_ctrl[MEM_CTRL_EN_BIT];
  assign pend     = mem_pend | if_req;
  assign busy     = (state == BUSY_IF) | (state == BUSY_MEM);
  assign done     = busy & (bus_ack | tmo);

  rr_grant2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_if   (if_req),
    .req_mem  (mem_pend),
    .take     (grant),
    .pick_mem (pick_mem),
    .last_mem (last_mem)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; a grant is only issued from IDLE, so RESP is a turnaround.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IDLE: if (pend) begin
        grant     = 1'b1;
        state_nxt = pick_mem ? BUSY_MEM : BUSY_IF;
      end
      BUSY_IF, BUSY_MEM: if (done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus request registers latched at grant, read data captured at completion.
  // A timed-out transaction returns zero to its requester; stores never touch
  // mem_rdata unless they time out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else if (grant) begin
      bus_req   <= 1'b1;
      bus_we    <= pick_mem & mem_ctrl[MEM_CTRL_WE_BIT];
      bus_addr  <= pick_mem ? mem_addr : if_addr;
      bus_wdata <= pick_mem ? mem_wdata : '0;
    end else if (done) begin
      bus_req <= 1'b0;
      if (state == BUSY_IF) if_rdata  <= tmo ? '0 : bus_rdata;
      else if (tmo)         mem_rdata <= '0;
      else if (!bus_we)     mem_rdata <= bus_rdata;
    end
  end

  assign if_ready  = (state == RESP) & ~last_mem;
  assign mem_ready = (state == RESP) &  last_mem;
  assign stall     = (mem_pend & ~mem_ready) | (if_req & ~if_ready);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] to_cnt;
  logic          err_q;

  assign tmo     = busy & ~bus_ack & (to_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign bus_err = err_q;

  // Busy-cycle counter, cleared at grant.
  always_ff @(posedge clk) begin
    if (!rst_n)     to_cnt <= '0;
    else if (grant) to_cnt <= '0;
    else if (busy)  to_cnt <= to_cnt + CW'(1);
  end

  // Error flag is set on abort and lives only for the RESP cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= tmo;
  end
`else
  assign tmo     = 1'b0;
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs are driven and outputs sampled
// on the falling edge. Define MEM_TIMEOUT_EN to exercise the timeout path.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic [1:0]    mem_ctrl;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          stall;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic          bus_err;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .mem_ctrl  (mem_ctrl),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall     (stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; mem_ctrl = 2'b00; mem_addr = '0;
    mem_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    step(); step();
    checks++; if ({bus_req, bus_we, if_ready, mem_ready, bus_err, stall} !== 6'b0) begin errors++;
      $display("FAIL reset_ctl: got %b want 000000", {bus_req, bus_we, if_ready, mem_ready, bus_err, stall}); end
    checks++; if ({bus_addr, bus_wdata, if_rdata, mem_rdata} !== 128'h0) begin errors++;
      $display("FAIL reset_data: got %h want 0", {bus_addr, bus_wdata, if_rdata, mem_rdata}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_wait_load();
    mem_ctrl = MEM_LOAD; mem_addr = 32'h100;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL zw_stall_req: got %b want 1", stall); end
    step();
    checks++; if ({bus_req, bus_we} !== 2'b10) begin errors++; $display("FAIL zw_req_we: got %b want 10", {bus_req, bus_we}); end
    checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL zw_addr: got %h want 100", bus_addr); end
    checks++; if ({stall, mem_ready} !== 2'b10) begin errors++; $display("FAIL zw_busy: got %b want 10", {stall, mem_ready}); end
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    step();
    checks++; if ({mem_ready, bus_req, stall} !== 3'b100) begin errors++; $display("FAIL zw_resp: got %b want 100", {mem_ready, bus_req, stall}); end
    checks++; if (mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_rdata: got %h want deadbeef", mem_rdata); end
    bus_ack = 1'b0; bus_rdata = '0; mem_ctrl = 2'b00;
    step();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL zw_pulse: got %b want 0", mem_ready); end
  endtask

  task automatic test_store_wait();
    mem_ctrl = MEM_STORE; mem_wdata = 32'h12345678; mem_addr = 32'h200;
    step();
    // Changes after the grant must not reach the bus.
    mem_wdata = 32'hFFFF0000; mem_addr = 32'h999; bus_rdata = 32'h0BAD0BAD;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus_req, bus_we, mem_ready, stall} !== 4'b1101) begin errors++;
        $display("FAIL st_busy%0d: got %b want 1101", i, {bus_req, bus_we, mem_ready, stall}); end
      checks++; if ({bus_addr, bus_wdata} !== {32'h200, 32'h12345678}) begin errors++;
        $display("FAIL st_hold%0d: got %h want 0000020012345678", i, {bus_addr, bus_wdata}); end
      if (i == 3) bus_ack = 1'b1;
      step();
    end
    checks++; if ({mem_ready, bus_req, bus_err} !== 3'b100) begin errors++; $display("FAIL st_resp: got %b want 100", {mem_ready, bus_req, bus_err}); end
    checks++; if (mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_rdata: got %h want deadbeef", mem_rdata); end
    bus_ack = 1'b0; mem_ctrl = 2'b00;
    step();
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL st_pulse: got %b want 0", mem_ready); end
  endtask

  task automatic test_round_robin();
    logic exp_mem;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h400; mem_ctrl = MEM_LOAD; mem_addr = 32'h300;
    for (int k = 0; k < 3; k++) begin
      exp_mem = (k != 1);
      step();
      checks++; if ({bus_req, bus_addr} !== {1'b1, exp_mem ? 32'h300 : 32'h400}) begin errors++;
        $display("FAIL rr_grant%0d: got %b/%h want mem=%b", k, bus_req, bus_addr, exp_mem); end
      bus_ack = 1'b1; bus_rdata = 32'hA0000000 + k;
      step();
      checks++; if ({mem_ready, if_ready, stall} !== {exp_mem, ~exp_mem, 1'b1}) begin errors++;
        $display("FAIL rr_ready%0d: got %b want %b", k, {mem_ready, if_ready, stall}, {exp_mem, ~exp_mem, 1'b1}); end
      checks++; if ((exp_mem ? mem_rdata : if_rdata) !== 32'hA0000000 + k) begin errors++;
        $display("FAIL rr_rdata%0d: got %h want %h", k, exp_mem ? mem_rdata : if_rdata, 32'hA0000000 + k); end
      bus_ack = 1'b0;
      if (k == 2) begin if_req = 1'b0; mem_ctrl = 2'b00; end
      step();
      checks++; if ({bus_req, if_ready, mem_ready} !== 3'b000) begin errors++;
        $display("FAIL rr_turn%0d: got %b want 000", k, {bus_req, if_ready, mem_ready}); end
    end
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h600;
    step();
    checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h600}) begin errors++; $display("FAIL rm_grant: got %b/%h want 1/600", bus_req, bus_addr); end
    step();
    rst_n = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h55;
    step();
    checks++; if ({bus_req, if_ready, bus_addr, if_rdata} !== 66'h0) begin errors++;
      $display("FAIL rm_abort: got %b%b/%h/%h want 0", bus_req, if_ready, bus_addr, if_rdata); end
    rst_n = 1'b1; if_req = 1'b0; bus_ack = 1'b0;
    step();
    checks++; if ({bus_req, if_ready, mem_ready} !== 3'b000) begin errors++; $display("FAIL rm_idle: got %b want 000", {bus_req, if_ready, mem_ready}); end
    mem_ctrl = MEM_LOAD; mem_addr = 32'h700;
    step();
    checks++; if ({bus_req, bus_addr} !== {1'b1, 32'h700}) begin errors++; $display("FAIL rm_regrant: got %b/%h want 1/700", bus_req, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h77;
    step();
    checks++; if ({mem_ready, mem_rdata} !== {1'b1, 32'h77}) begin errors++; $display("FAIL rm_load: got %b/%h want 1/77", mem_ready, mem_rdata); end
    bus_ack = 1'b0; mem_ctrl = 2'b00;
    step();
  endtask

  task automatic test_stray_ack();
    bus_ack = 1'b1; bus_rdata = 32'h1111;
    mem_ctrl = 2'b01; // enable bit clear: no access
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({bus_req, if_ready, mem_ready, stall, bus_err} !== 5'b0) begin errors++;
        $display("FAIL sa_idle%0d: got %b want 00000", i, {bus_req, if_ready, mem_ready, stall, bus_err}); end
    end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL sa_rdata: got %h want 0", if_rdata); end
    bus_ack = 1'b0; mem_ctrl = 2'b00; if_req = 1'b1; if_addr = 32'h800;
    step();
    checks++; if ({bus_req, bus_we, bus_addr} !== {2'b10, 32'h800}) begin errors++; $display("FAIL sa_grant: got %b%b/%h want 10/800", bus_req, bus_we, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    step();
    checks++; if ({if_ready, stall, if_rdata} !== {2'b10, 32'hCAFEF00D}) begin errors++;
      $display("FAIL sa_if: got %b%b/%h want 10/cafef00d", if_ready, stall, if_rdata); end
    bus_ack = 1'b0; if_req = 1'b0;
    step();
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL sa_pulse: got %b want 0", if_ready); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    mem_ctrl = MEM_LOAD; mem_addr = 32'h900;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus_req, bus_err, mem_ready} !== 3'b100) begin errors++;
        $display("FAIL to_busy%0d: got %b want 100", i, {bus_req, bus_err, mem_ready}); end
      step();
    end
    checks++; if ({bus_req, bus_err, mem_ready} !== 3'b011) begin errors++; $display("FAIL to_abort: got %b want 011", {bus_req, bus_err, mem_ready}); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h want 0", mem_rdata); end
    mem_ctrl = 2'b00;
    step();
    checks++; if ({bus_err, mem_ready} !== 2'b00) begin errors++; $display("FAIL to_pulse: got %b want 00", {bus_err, mem_ready}); end
  endtask
`else
  task automatic test_timeout();
    mem_ctrl = MEM_LOAD; mem_addr = 32'h900;
    step();
    for (int i = 0; i < 10; i++) begin
      checks++; if ({bus_req, bus_err, mem_ready} !== 3'b100) begin errors++;
        $display("FAIL nt_wait%0d: got %b want 100", i, {bus_req, bus_err, mem_ready}); end
      step();
    end
    bus_ack = 1'b1; bus_rdata = 32'h99;
    step();
    checks++; if ({mem_ready, bus_err, mem_rdata} !== {2'b10, 32'h99}) begin errors++;
      $display("FAIL nt_done: got %b%b/%h want 10/99", mem_ready, bus_err, mem_rdata); end
    bus_ack = 1'b0; mem_ctrl = 2'b00;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_round_robin();
    test_reset_mid();
    test_stray_ack();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
